// File: rtl/approx_adder_err_monitor.sv
// Two-stage approximate adder (exact / ETA-II / LOA) with exact reference, error distance and
// optional running error statistics (enabled by defining APPROX_ERR_STATS_EN).
module approx_adder_err_monitor #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_apx,
  output logic             cout_apx,
  output logic [WIDTH:0]   sum_exact,
  output logic [WIDTH:0]   err_dist,
  output logic             err_flag,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   max_err,
  output logic [CNT_W-1:0] acc_err
);

  localparam int NSEG = WIDTH / SEG;

  typedef enum logic [1:0] {
    MODE_RCA   = 2'd0,
    MODE_ETA2  = 2'd1,
    MODE_LOA   = 2'd2,
    MODE_EXACT = 2'd3
  } mode_e;

  // Each segment's carry-in is the carry the previous segment would produce on its own,
  // so carry chains never span more than two segments.
  function automatic logic [WIDTH:0] eta2_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    logic [SEG:0]   seg_sum;
    logic [SEG:0]   seg_plain;
    logic           cin;
    r   = '0;
    cin = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      seg_sum   = {1'b0, x[i*SEG +: SEG]} + {1'b0, y[i*SEG +: SEG]} + {{SEG{1'b0}}, cin};
      seg_plain = {1'b0, x[i*SEG +: SEG]} + {1'b0, y[i*SEG +: SEG]};
      r[i*SEG +: SEG] = seg_sum[SEG-1:0];
      if (i == NSEG - 1) r[WIDTH] = seg_sum[SEG];
      cin = seg_plain[SEG];
    end
    return r;
  endfunction

  // Lower part is a carry-free OR; the top lower bit pair predicts the carry into the exact upper add.
  function automatic logic [WIDTH:0] loa_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-SEG:0] hi;
    hi = {1'b0, x[WIDTH-1:SEG]} + {1'b0, y[WIDTH-1:SEG]}
       + {{(WIDTH-SEG){1'b0}}, x[SEG-1] & y[SEG-1]};
    return {hi, x[SEG-1:0] | y[SEG-1:0]};
  endfunction

  // Pipeline control
  logic             rdy_en;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  mode_e            s1_mode;
  logic             s2_load;
  logic             s1_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  // rdy_en keeps in_ready low while in reset and for the cycle before the first edge after release.
  assign in_ready = rdy_en && s1_load;

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_RCA;
    end else if (s1_load) begin
      s1_valid <= in_valid && rdy_en;
      if (in_valid && rdy_en) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_mode <= mode_e'(mode);
      end
    end
  end

  // Stage-2 datapath
  logic [WIDTH:0] exact_c;
  logic [WIDTH:0] apx_c;
  logic [WIDTH:0] err_c;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    exact_c = {1'b0, s1_a} + {1'b0, s1_b};
    apx_c   = exact_c;
    case (s1_mode)
      MODE_ETA2: apx_c = eta2_add(s1_a, s1_b);
      MODE_LOA:  apx_c = loa_add(s1_a, s1_b);
      default:   apx_c = exact_c;
    endcase
    err_c = (exact_c >= apx_c) ? (exact_c - apx_c) : (apx_c - exact_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum_apx   <= '0;
      cout_apx  <= 1'b0;
      sum_exact <= '0;
      err_dist  <= '0;
      err_flag  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum_apx   <= apx_c[WIDTH-1:0];
        cout_apx  <= apx_c[WIDTH];
        sum_exact <= exact_c;
        err_dist  <= err_c;
        err_flag  <= (err_c != '0);
      end
    end
  end

`ifdef APPROX_ERR_STATS_EN
  localparam int AW = ((CNT_W > WIDTH + 1) ? CNT_W : (WIDTH + 1)) + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [WIDTH:0] e);
    logic [AW-1:0] s;
    s = AW'(c) + AW'(e);
    return (s > AW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic out_fire;
  assign out_fire = out_valid && out_ready;

  // Statistics observe the result currently presented, and a clear discards that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_err    <= '0;
      acc_err    <= '0;
    end else if (stat_clear) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_err    <= '0;
      acc_err    <= '0;
    end else if (out_fire) begin
      sample_cnt <= sat_inc(sample_cnt);
      if (err_flag)           err_cnt <= sat_inc(err_cnt);
      if (err_dist > max_err) max_err <= err_dist;
      acc_err <= sat_add(acc_err, err_dist);
    end
  end
`else
  logic unused_stat_clear;
  assign unused_stat_clear = stat_clear;
  assign sample_cnt = '0;
  assign err_cnt    = '0;
  assign max_err    = '0;
  assign acc_err    = '0;
`endif

endmodule
